uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Round-robin scheduler sharing one UART transmitter between NUM_REQ requesters.
//  Picks a requester, latches its byte, and drives the transmitter's active-low
//  send strobe (a high cycle to arm it, then low). Tracks the transmitter's busy
//  flag through the frame, then enforces a stop/idle gap before acking and rearbitrating.
//  Sits between client logic and the UART TX datapath.
// PARAMETERS
//  NUM_REQ       4    number of requesters (2..8)
//  DATA_LEN      8    frame data width; must match the transmitter
//  STOP_CYCLES   44   idle clks after busy falls (>= one bit time: 5e6/BAUD+1)
//  START_TIMEOUT 16   max clks in STROBE awaiting busy rise (TXSCH_TIMEOUT_EN only)
// PORTS
//  clk          in   1                 system clock, rising edge
//  rst_n        in   1                 async active-low reset
//  req          in   NUM_REQ           per-requester request level, held until ack
//  req_data     in   NUM_REQ*DATA_LEN  requester i byte at [i*DATA_LEN +: DATA_LEN]
//  ack          out  NUM_REQ           one-hot, 1-clk pulse: frame of requester i done
//  tx_data      out  DATA_LEN          byte to transmitter, stable ARM..XMIT
//  tx_send_n    out  1                 active-low send strobe to transmitter
//  tx_busy      in   1                 transmitter busy (high while frame shifts)
//  active_id    out  $clog2(NUM_REQ)   index of requester being served
//  sched_busy   out  1                 high in any state other than IDLE
//  timeout_err  out  1                 1-clk pulse with ack on start timeout
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, tx_send_n=1, tx_data=0, ack=0,
//   active_id=0, sched_busy=0, timeout_err=0, rr_ptr=NUM_REQ-1 (req0 wins first).
//  States / transitions (one per clk):
//   IDLE   : if |req && !tx_busy -> winner = first set req scanning rr_ptr+1 upward
//            with wrap; latch req_data slice into tx_data, active_id=winner,
//            rr_ptr=winner -> ARM. tx_busy=1 in IDLE (frame left over after
//            reset) blocks grant until it falls.
//   ARM    : tx_send_n=1 for exactly 1 clk (arms transmitter) -> STROBE.
//   STROBE : tx_send_n=0; on tx_busy=1 -> tx_send_n=1 next clk, -> XMIT.
//   XMIT   : tx_send_n=1; wait tx_busy=0 -> GAP, gap counter cleared.
//   GAP    : count STOP_CYCLES clks with tx_send_n=1; on last count pulse
//            ack[active_id] for 1 clk -> IDLE.
//  Latency: IDLE grant -> tx_send_n low = 2 clks; min req-to-ack =
//   2 + transmitter start + frame + STOP_CYCLES.
//  Boundary rules:
//   - req dropped after grant: frame still completes, ack still pulses.
//   - req_data change after latch: ignored until next grant.
//   - Same requester re-requesting: served again only after all other active
//     requesters (strict rotation from rr_ptr).
//   - Single requester: back-to-back frames separated by >= STOP_CYCLES + 2 clks.
//   - ack and new grant never in same clk (ack clk is GAP->IDLE exit).
//   - Counters: gap/timeout counters width $clog2(max+1), saturate, never wrap.
//   - Reset mid-frame: outputs to reset values immediately; transmitter frame
//     may continue; IDLE waits for tx_busy=0 before next grant.
// CONFIGURATION
//  TXSCH_TIMEOUT_EN defined: STROBE counts clks; if tx_busy not high after
//   START_TIMEOUT clks -> tx_send_n=1, ack[active_id] and timeout_err pulse
//   together for 1 clk, -> IDLE (frame dropped, rr_ptr already advanced).
//  Not defined: STROBE waits indefinitely; timeout_err tied 0; no counter logic.
// TESTING
//  1 rst_n=0 mid-STROBE -> tx_send_n=1, ack=0, sched_busy=0 same clk, async.
//  2 req=4'b0001, data0=8'hA5, transmitter model busy 3 clks after strobe ->
//    tx_data=A5, tx_send_n high 1 clk then low until busy, ack=0001 once.
//  3 req=4'b1111 held -> grant order 0,1,2,3,0; consecutive frames spaced
//    >= STOP_CYCLES clks of busy=0 before next tx_send_n fall.
//  4 req1 raised during req0 frame, req0 dropped mid-frame -> ack0 pulses,
//    then req1 served with its own data, no second req0 frame.
//  5 tx_busy forced 1 at reset release, req=0010 -> no grant until busy=0.
//  6 TXSCH_TIMEOUT_EN, tx_busy stuck 0 -> after 16 clks in STROBE ack and
//    timeout_err pulse together, tx_send_n=1; without macro stays in STROBE.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_scheduler_if                                                       |
// | Requester / UART-transmitter bundle shared by the round-robin TX scheduler |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_LEN = 8
);
    localparam int c_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*DATA_LEN-1:0] req_data;
    logic [NUM_REQ-1:0]          ack;
    logic [DATA_LEN-1:0]         tx_data;
    logic                        tx_send_n;
    logic                        tx_busy;
    logic [c_ID_W-1:0]           active_id;
    logic                        sched_busy;
    logic                        timeout_err;

    // master: the scheduler itself
    modport master (
        input  req, req_data, tx_busy,
        output ack, tx_data, tx_send_n, active_id, sched_busy, timeout_err
    );

    // slave: requesters plus transmitter as seen by the scheduler
    modport slave (
        output req, req_data, tx_busy,
        input  ack, tx_data, tx_send_n, active_id, sched_busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_tx_scheduler                                                          |
// | Round-robin sharing of one UART transmitter between NUM_REQ requesters.    |
// | Optional STROBE start timeout: define TXSCH_TIMEOUT_EN.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module uart_tx_scheduler #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_LEN      = 8,
    parameter int STOP_CYCLES   = 44,
    parameter int START_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    uart_tx_scheduler_if.master bus
);
    localparam int c_ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_GAP_W = $clog2(STOP_CYCLES + 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_ARM    = 3'd1;
    localparam logic [2:0] c_STROBE = 3'd2;
    localparam logic [2:0] c_XMIT   = 3'd3;
    localparam logic [2:0] c_GAP    = 3'd4;

    logic [2:0]          r_state;
    logic                r_tx_send_n;
    logic [DATA_LEN-1:0] r_tx_data;
    logic [NUM_REQ-1:0]  r_ack;
    logic [c_ID_W-1:0]   r_active_id;
    logic [c_ID_W-1:0]   r_rr_ptr;
    logic [c_GAP_W-1:0]  r_gap_cnt;

    logic                w_grant_vld;
    logic [c_ID_W-1:0]   w_winner;
    logic [NUM_REQ-1:0]  w_ack_onehot;

`ifdef TXSCH_TIMEOUT_EN
    localparam int c_TO_W = $clog2(START_TIMEOUT + 1);
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                r_timeout_err;
    assign bus.timeout_err = r_timeout_err;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // Scan downward so the closest set request after rr_ptr overwrites the rest.
    always_comb begin
        w_grant_vld = 1'b0;
        w_winner    = r_rr_ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_grant_vld = 1'b1;
                w_winner    = c_ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_ack_onehot = NUM_REQ'(1) << r_active_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_tx_send_n <= 1'b1;
            r_tx_data   <= '0;
            r_ack       <= '0;
            r_active_id <= '0;
            r_rr_ptr    <= c_ID_W'(NUM_REQ - 1);
            r_gap_cnt   <= '0;
`ifdef TXSCH_TIMEOUT_EN
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_ack <= '0;
`ifdef TXSCH_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                c_IDLE: begin
                    r_tx_send_n <= 1'b1;
                    // The ack cycle itself is never a grant cycle.
                    if (w_grant_vld && !bus.tx_busy && !(|r_ack)) begin
                        r_tx_data   <= bus.req_data[int'(w_winner) * DATA_LEN +: DATA_LEN];
                        r_active_id <= w_winner;
                        r_rr_ptr    <= w_winner;
                        r_state     <= c_ARM;
                    end
                end
                c_ARM: begin
                    r_tx_send_n <= 1'b0;
                    r_state     <= c_STROBE;
`ifdef TXSCH_TIMEOUT_EN
                    r_to_cnt    <= '0;
`endif
                end
                c_STROBE: begin
                    if (bus.tx_busy) begin
                        r_tx_send_n <= 1'b1;
                        r_state     <= c_XMIT;
                    end
`ifdef TXSCH_TIMEOUT_EN
                    else if (r_to_cnt >= c_TO_W'(START_TIMEOUT - 1)) begin
                        r_tx_send_n   <= 1'b1;
                        r_ack         <= w_ack_onehot;
                        r_timeout_err <= 1'b1;
                        r_state       <= c_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                c_XMIT: begin
                    r_tx_send_n <= 1'b1;
                    if (!bus.tx_busy) begin
                        r_gap_cnt <= '0;
                        r_state   <= c_GAP;
                    end
                end
                c_GAP: begin
                    r_tx_send_n <= 1'b1;
                    if (r_gap_cnt >= c_GAP_W'(STOP_CYCLES - 1)) begin
                        r_ack   <= w_ack_onehot;
                        r_state <= c_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx_send_n <= 1'b1;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_send_n  = r_tx_send_n;
    assign bus.tx_data    = r_tx_data;
    assign bus.ack        = r_ack;
    assign bus.active_id  = r_active_id;
    assign bus.sched_busy = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_tx_scheduler                                                       |
// | Self-checking bench: vector table, directed corner cases, random traffic.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_uart_tx_scheduler;
    localparam int NR        = 4;
    localparam int DL        = 8;
    localparam int STOP      = 8;
    localparam int TO        = 16;
    localparam int START_DLY = 3;
    localparam int FRAME     = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.NUM_REQ(NR), .DATA_LEN(DL)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ(NR), .DATA_LEN(DL), .STOP_CYCLES(STOP), .START_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit tx_stuck    = 1'b0;
    bit force_busy  = 1'b0;
    bit model_clear = 1'b0;

    // Transmitter model: busy rises START_DLY clks after the strobe, lasts FRAME clks.
    initial begin
        int  start_cnt = 0;
        int  xmit_cnt  = 0;
        bit  busy_m    = 1'b0;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (model_clear) begin
                start_cnt = 0; xmit_cnt = 0; busy_m = 1'b0;
            end else if (xmit_cnt > 0) begin
                xmit_cnt--;
                if (xmit_cnt == 0) busy_m = 1'b0;
            end else if (start_cnt > 0) begin
                start_cnt--;
                if (start_cnt == 0) begin busy_m = 1'b1; xmit_cnt = FRAME; end
            end else if (!tx_stuck && bus.tx_send_n === 1'b0 && !busy_m) begin
                start_cnt = START_DLY;
            end
            bus.tx_busy = busy_m | force_busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference arbitration: first set request after ptr, wrapping.
    function automatic int rr_pick(int ptr, logic [NR-1:0] r);
        for (int k = 1; k <= NR; k++)
            if (r[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        model_clear = 1'b1;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        model_clear = 1'b0;
        step();
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (bus.sched_busy !== 1'b1 && n < 50) begin step(); n++; end
        check({tag, "_grant_wait"}, 32'(bus.sched_busy), 32'd1);
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        while (bus.ack === '0 && n < 300) begin step(); n++; end
        check({tag, "_ack_wait"}, 32'(|bus.ack), 32'd1);
    endtask

    typedef struct {
        logic [NR-1:0]    req;
        logic [NR*DL-1:0] data;
        int               exp_id;
        logic [DL-1:0]    exp_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'b0001, 32'h4433_22A5, 0, 8'hA5};
        vecs[1] = '{4'b1111, 32'h9C8B_7A69, 1, 8'h7A};
        vecs[2] = '{4'b0101, 32'h1020_3040, 2, 8'h20};
        vecs[3] = '{4'b0011, 32'hDEAD_BEEF, 0, 8'hEF};
        vecs[4] = '{4'b1000, 32'h0102_0304, 3, 8'h01};
        vecs[5] = '{4'b1001, 32'hF0E1_D2C3, 0, 8'hC3};
        vecs[6] = '{4'b0001, 32'h5566_7788, 0, 8'h88};
        vecs[7] = '{4'b1110, 32'hAABB_CCDD, 1, 8'hCC};

        bus.req = '0;
        bus.req_data = '0;
        do_reset();

        check("rst_sched_busy", 32'(bus.sched_busy), 32'd0);
        check("rst_send_n",     32'(bus.tx_send_n),  32'd1);
        check("rst_ack",        32'(bus.ack),        32'd0);
        check("rst_tx_data",    32'(bus.tx_data),    32'd0);
        check("rst_active_id",  32'(bus.active_id),  32'd0);
        check("rst_timeout",    32'(bus.timeout_err), 32'd0);

        // Vector table: rotation, data latch, strobe shape, ack pulse.
        for (int i = 0; i < 8; i++) begin
            bus.req      = vecs[i].req;
            bus.req_data = vecs[i].data;
            wait_grant("tbl");
            check("tbl_id",       32'(bus.active_id), 32'(vecs[i].exp_id));
            check("tbl_data",     32'(bus.tx_data),   32'(vecs[i].exp_data));
            check("tbl_arm_high", 32'(bus.tx_send_n), 32'd1);
            bus.req_data = {$urandom, $urandom};
            step();
            check("tbl_strobe_low", 32'(bus.tx_send_n), 32'd0);
            wait_ack("tbl");
            check("tbl_ack",       32'(bus.ack),         32'(1 << vecs[i].exp_id));
            check("tbl_data_held", 32'(bus.tx_data),     32'(vecs[i].exp_data));
            check("tbl_no_to",     32'(bus.timeout_err), 32'd0);
            bus.req = '0;
            step();
            check("tbl_ack_pulse", 32'(bus.ack), 32'd0);
        end

        // Asynchronous reset while in STROBE.
        do_reset();
        tx_stuck = 1'b1;
        bus.req = 4'b0001;
        bus.req_data = 32'h0000_00A5;
        wait_grant("t1");
        step(); step();
        check("t1_in_strobe", 32'(bus.tx_send_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_send_n", 32'(bus.tx_send_n),  32'd1);
        check("t1_async_sbusy",  32'(bus.sched_busy), 32'd0);
        check("t1_async_ack",    32'(bus.ack),        32'd0);
        check("t1_async_data",   32'(bus.tx_data),    32'd0);
        bus.req = '0;
        step();
        rst_n = 1'b1;
        step();

        // Start timeout (transmitter never answers).
        do_reset();
        tx_stuck = 1'b1;
        bus.req = 4'b0100;
        bus.req_data = 32'h0077_0000;
        wait_grant("t6");
        check("t6_id", 32'(bus.active_id), 32'd2);
        step();
        begin
            int low_cnt = 0;
            while (bus.tx_send_n === 1'b0 && low_cnt < 100) begin low_cnt++; step(); end
`ifdef TXSCH_TIMEOUT_EN
            check("t6_strobe_len", 32'(low_cnt),         32'(TO));
            check("t6_ack",        32'(bus.ack),         32'b0100);
            check("t6_timeout",    32'(bus.timeout_err), 32'd1);
            check("t6_send_n",     32'(bus.tx_send_n),   32'd1);
            bus.req = '0;
            step();
            check("t6_timeout_pulse", 32'(bus.timeout_err), 32'd0);
`else
            check("t6_strobe_len", 32'(low_cnt),         32'd100);
            check("t6_still_busy", 32'(bus.sched_busy),  32'd1);
            check("t6_no_timeout", 32'(bus.timeout_err), 32'd0);
            check("t6_no_ack",     32'(bus.ack),         32'd0);
`endif
        end
        tx_stuck = 1'b0;
        bus.req = '0;
        do_reset();

        // req0 dropped mid-frame while req1 arrives.
        bus.req_data = 32'h0000_2211;
        bus.req = 4'b0001;
        wait_grant("t4a");
        check("t4_first_id", 32'(bus.active_id), 32'd0);
        begin
            int n = 0;
            while (bus.tx_busy !== 1'b1 && n < 20) begin step(); n++; end
        end
        bus.req = 4'b0010;
        bus.req_data = 32'h0000_2299;
        wait_ack("t4a");
        check("t4_ack0",      32'(bus.ack),     32'b0001);
        check("t4_data0_hold", 32'(bus.tx_data), 32'h11);
        step();
        wait_grant("t4b");
        check("t4_second_id",   32'(bus.active_id), 32'd1);
        check("t4_second_data", 32'(bus.tx_data),   32'h22);
        wait_ack("t4b");
        check("t4_ack1", 32'(bus.ack), 32'b0010);
        bus.req = '0;
        begin
            int extra = 0;
            for (int i = 0; i < 60; i++) begin step(); if (bus.sched_busy) extra++; end
            check("t4_no_extra_frame", 32'(extra), 32'd0);
        end

        // Transmitter busy at reset release blocks the grant.
        force_busy = 1'b1;
        do_reset();
        bus.req = 4'b0010;
        bus.req_data = 32'h0000_5A00;
        repeat (20) step();
        check("t5_blocked", 32'(bus.sched_busy), 32'd0);
        force_busy = 1'b0;
        wait_grant("t5");
        check("t5_id",   32'(bus.active_id), 32'd1);
        check("t5_data", 32'(bus.tx_data),   32'h5A);
        wait_ack("t5");
        check("t5_ack", 32'(bus.ack), 32'b0010);
        bus.req = '0;
        step();

        // Random traffic against the rotation/latch/gap reference model.
        do_reset();
        begin
            int mptr = NR - 1;
            int cur  = -1;
            int acks = 0;
            int busy_fall = -1;
            logic [DL-1:0] gdata = '0;
            logic prev_sb = 1'b0, prev_busy = 1'b0, prev_send_n = 1'b1;
            for (int cyc = 0; cyc < 8000 && acks < 40; cyc++) begin
                step();
                if (bus.sched_busy && !prev_sb) begin
                    int exp_id;
                    exp_id = rr_pick(mptr, bus.req);
                    check("rnd_grant_id", 32'(bus.active_id), 32'(exp_id));
                    if (exp_id >= 0) begin
                        gdata = bus.req_data[exp_id*DL +: DL];
                        check("rnd_grant_data", 32'(bus.tx_data), 32'(gdata));
                        mptr = exp_id;
                    end
                    cur = exp_id;
                end
                if (bus.ack !== '0) begin
                    check("rnd_ack",       32'(bus.ack),     (cur >= 0) ? 32'(1 << cur) : 32'd0);
                    check("rnd_data_held", 32'(bus.tx_data), 32'(gdata));
                    acks++;
                    if (cur >= 0) bus.req[cur] = 1'b0;
                    cur = -1;
                end
                if (prev_busy && !bus.tx_busy) busy_fall = cyc;
                if (prev_send_n && !bus.tx_send_n && busy_fall >= 0)
                    check("rnd_gap_ok", 32'(cyc - busy_fall >= STOP), 32'd1);
                prev_sb     = bus.sched_busy;
                prev_busy   = bus.tx_busy;
                prev_send_n = bus.tx_send_n;
                for (int i = 0; i < NR; i++) begin
                    if (i == cur) begin
                        if ($urandom_range(0, 7) == 0) bus.req_data[i*DL +: DL] = DL'($urandom);
                        if (bus.req[i] && $urandom_range(0, 31) == 0) bus.req[i] = 1'b0;
                    end else if (!bus.req[i]) begin
                        if ($urandom_range(0, 7) == 0) begin
                            bus.req[i] = 1'b1;
                            bus.req_data[i*DL +: DL] = DL'($urandom);
                        end
                    end else if ($urandom_range(0, 15) == 0) begin
                        bus.req_data[i*DL +: DL] = DL'($urandom);
                    end
                end
            end
            check("rnd_progress", 32'(acks >= 40), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
